// File: rtl/cmd_decoder.sv
// cmd_decoder: receive-side framer for PREFIX,DEST,LEN,DATA[LEN],CRC frames.
// The payload is staged in a 256x8 buffer. Once the CRC checks out, the payload
// is replayed to the addressed sink over a valid/ready stream.
module cmd_decoder #(
  parameter logic [7:0] PREFIX  = 8'hAA,
  parameter int         N_DEST  = 4,
  parameter int         TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_dest,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       dest_err,
  output logic       len_err,
  output logic       tmo_err,
  output logic       drop_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEST  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam int          TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [7:0]    dest_q, len_q, crc_q, wr_ptr, rd_ptr;
  logic          bad_dest, primed;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    out_data_q;
  logic          out_valid_q, out_last_q;
  logic [7:0]    mem [256];

  assign out_data  = out_data_q;
  assign out_dest  = dest_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  // Payload buffer write port. This is plain storage with no reset, so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (state == S_DATA && rx_valid) mem[wr_ptr] <= rx_data;
  end

  // Frame parser, inter-byte timeout and drain sequencer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      crc_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bad_dest    <= 1'b0;
      primed      <= 1'b0;
      tmo_cnt     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      dest_err    <= 1'b0;
      len_err     <= 1'b0;
      tmo_err     <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      crc_err  <= 1'b0;
      dest_err <= 1'b0;
      len_err  <= 1'b0;
      tmo_err  <= 1'b0;
      drop_err <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid && rx_data == PREFIX) state <= S_DEST;
        end
        S_DEST, S_LEN, S_DATA, S_CRC: begin
          if (rx_valid) begin
            // An arriving byte always beats an expiry on the same edge.
            tmo_cnt <= '0;
            case (state)
              S_DEST: begin
                dest_q   <= rx_data;
                crc_q    <= rx_data;
                bad_dest <= int'(rx_data) >= N_DEST;
                state    <= S_LEN;
              end
              S_LEN: begin
                if (rx_data == 8'd0) begin
                  len_err <= 1'b1;
                  state   <= S_IDLE;
                end else begin
                  len_q  <= rx_data;
                  crc_q  <= crc_q + rx_data;
                  wr_ptr <= '0;
                  state  <= S_DATA;
                end
              end
              S_DATA: begin
                crc_q  <= crc_q + rx_data;
                wr_ptr <= wr_ptr + 8'd1;
                if (wr_ptr == len_q - 8'd1) state <= S_CRC;
              end
              default: begin
                // CRC byte: a mismatch is reported ahead of a bad destination.
                if (rx_data != crc_q) begin
                  crc_err <= 1'b1;
                  state   <= S_IDLE;
                end else if (bad_dest) begin
                  dest_err <= 1'b1;
                  state    <= S_IDLE;
                end else begin
                  frame_ok <= 1'b1;
                  rd_ptr   <= '0;
                  primed   <= 1'b0;
                  state    <= S_DRAIN;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_err <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_DRAIN: begin
          // The stream owns the buffer now, so any incoming byte is dropped.
          if (rx_valid) drop_err <= 1'b1;
          if (!primed) begin
            // Registered read of byte 0. Valid follows on the next edge.
            out_data_q <= mem[rd_ptr];
            primed     <= 1'b1;
          end else if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (len_q == 8'd1);
          end else if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state       <= S_IDLE;
            end else begin
              // Prefetch the next byte on the transfer edge to keep 1 byte/clk.
              rd_ptr     <= rd_ptr + 8'd1;
              out_data_q <= mem[rd_ptr + 8'd1];
              out_last_q <= (rd_ptr + 8'd1) == (len_q - 8'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Testbench for cmd_decoder: scoreboard of expected stream beats plus pulse counters.
module tb_cmd_decoder;
  localparam logic [7:0] PFX   = 8'hAA;
  localparam int         NDEST = 4;
  localparam int         TMO   = 40;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data, out_dest;
  logic       out_last, out_valid, out_ready;
  logic       frame_ok, crc_err, dest_err, len_err, tmo_err, drop_err;

  cmd_decoder #(.PREFIX(PFX), .N_DEST(NDEST), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .frame_ok(frame_ok),
    .crc_err(crc_err), .dest_err(dest_err), .len_err(len_err),
    .tmo_err(tmo_err), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb [$];
  logic [7:0]  payload [256];
  int n_ok = 0, n_crc = 0, n_dest = 0, n_len = 0, n_tmo = 0, n_drop = 0, n_vld = 0;
  logic        stall_q = 1'b0;
  logic [16:0] held;
  logic [16:0] exp_beat;

  // Monitor: count pulses, check the hold-while-stalled rule and score every transfer.
  always @(negedge clk) begin
    if (!n_rst) begin
      stall_q = 1'b0;
    end else begin
      if (frame_ok) n_ok++;
      if (crc_err)  n_crc++;
      if (dest_err) n_dest++;
      if (len_err)  n_len++;
      if (tmo_err)  n_tmo++;
      if (drop_err) n_drop++;
      if (out_valid) n_vld++;
      if (stall_q) begin
        checks++;
        if ({out_valid, out_dest, out_data, out_last} !== {1'b1, held}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h/%h/%b want v=1 %h/%h/%b",
                   out_valid, out_dest, out_data, out_last, held[16:9], held[8:1], held[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h/%h/%b want none", out_dest, out_data, out_last);
        end else begin
          exp_beat = sb.pop_front();
          if ({out_dest, out_data, out_last} !== exp_beat) begin
            errors++;
            $display("FAIL beat: got dest %h data %h last %b want dest %h data %h last %b",
                     out_dest, out_data, out_last, exp_beat[16:9], exp_beat[8:1], exp_beat[0]);
          end
        end
      end
      stall_q = out_valid && !out_ready;
      held    = {out_dest, out_data, out_last};
    end
  end

  function automatic logic [47:0] snap();
    return {n_ok[7:0], n_crc[7:0], n_dest[7:0], n_len[7:0], n_tmo[7:0], n_drop[7:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends a frame built from payload[]. crc_adj corrupts the CRC. push queues the expected beats.
  task automatic send_frame(input logic [7:0] dest, input int len, input logic [7:0] crc_adj, input bit push);
    logic [7:0] crc;
    crc = dest + 8'(len);
    for (int i = 0; i < len; i++) crc = crc + payload[i];
    if (push) for (int i = 0; i < len; i++) sb.push_back({dest, payload[i], i == len - 1});
    send_byte(PFX); send_byte(dest); send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(payload[i]);
    send_byte(crc + crc_adj);
  endtask

  task automatic wait_drain(input int maxc);
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < maxc) begin idle(1); k++; end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", sb.size());
    end
  endtask

  task automatic wait_valid(input int maxc);
    int k;
    k = 0;
    while (!out_valid && k < maxc) begin idle(1); k++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: got out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; rx_valid = 1'b0; rx_data = '0; out_ready = 1'b0;
    idle(3);
    checks++;
    if ({out_valid, out_last, out_data, out_dest} !== 18'd0) begin
      errors++;
      $display("FAIL reset_stream: got %h want 0", {out_valid, out_last, out_data, out_dest});
    end
    checks++;
    if ({frame_ok, crc_err, dest_err, len_err, tmo_err, drop_err} !== 6'd0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 000000", {frame_ok, crc_err, dest_err, len_err, tmo_err, drop_err});
    end
    n_rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [47:0] base;
    base = snap();
    out_ready = 1'b1;
    payload[0] = 8'h11; payload[1] = 8'h22;
    send_frame(8'h03, 2, 8'h00, 1'b1);
    checks++;
    if (frame_ok !== 1'b1) begin errors++; $display("FAIL basic_ok_pulse: got %b want 1", frame_ok); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e0: got %b want 0", out_valid); end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e1: got %b want 0", out_valid); end
    idle(1);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL basic_valid_e2: got %b/%h want 1/11", out_valid, out_data);
    end
    wait_drain(20);
    checks++;
    if (snap() !== base + {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL basic_pulses: got %h want %h", snap(), base + {8'd1, 40'd0});
    end
  endtask

  task automatic test_crc_err();
    logic [47:0] base;
    int v0;
    base = snap(); v0 = n_vld;
    payload[0] = 8'h11; payload[1] = 8'h22;
    send_frame(8'h03, 2, 8'h01, 1'b0);
    checks++;
    if (crc_err !== 1'b1) begin errors++; $display("FAIL crc_pulse: got %b want 1", crc_err); end
    idle(5);
    checks++;
    if (n_vld !== v0) begin errors++; $display("FAIL crc_no_output: got %0d valid cycles want 0", n_vld - v0); end
    send_frame(8'h03, 2, 8'h00, 1'b1);
    wait_drain(20);
    checks++;
    if (snap() !== base + {8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL crc_pulses: got %h want %h", snap(), base + {8'd1, 8'd1, 32'd0});
    end
  endtask

  task automatic test_dest_len();
    logic [47:0] base;
    int v0;
    base = snap(); v0 = n_vld;
    payload[0] = 8'h55;
    send_frame(8'(NDEST), 1, 8'h00, 1'b0);
    checks++;
    if (dest_err !== 1'b1) begin errors++; $display("FAIL dest_pulse: got %b want 1", dest_err); end
    send_byte(PFX); send_byte(8'h01); send_byte(8'h00);
    checks++;
    if (len_err !== 1'b1) begin errors++; $display("FAIL len_pulse: got %b want 1", len_err); end
    idle(4);
    checks++;
    if (n_vld !== v0) begin errors++; $display("FAIL dest_len_no_output: got %0d want 0", n_vld - v0); end
    payload[0] = PFX;
    send_frame(8'h00, 1, 8'h00, 1'b1);
    wait_drain(20);
    checks++;
    if (snap() !== base + {8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0}) begin
      errors++; $display("FAIL dest_len_pulses: got %h want %h", snap(), base + {8'd1, 8'd0, 8'd1, 8'd1, 16'd0});
    end
  endtask

  task automatic test_backpressure();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    payload[0] = 8'hA1; payload[1] = 8'hB2; payload[2] = 8'hC3; payload[3] = 8'hD4;
    send_frame(8'h02, 4, 8'h00, 1'b1);
    wait_valid(10);
    for (int i = 0; i < 7; i++) begin out_ready = pat[i]; idle(1); end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_done: got pending %0d valid %b want 0/0", sb.size(), out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_timeout();
    logic [47:0] base;
    base = snap();
    send_byte(PFX); send_byte(8'h05); send_byte(8'h03);
    idle(TMO - 1);
    send_byte(8'h01);
    checks++;
    if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_byte_wins: got %b want 0", tmo_err); end
    idle(TMO - 1);
    checks++;
    if (n_tmo !== int'(base[15:8])) begin errors++; $display("FAIL tmo_early: got %0d want %0d", n_tmo, base[15:8]); end
    idle(1);
    checks++;
    if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", tmo_err); end
    payload[0] = 8'h10; payload[1] = 8'hF0; payload[2] = 8'h7E;
    send_frame(8'h01, 3, 8'h00, 1'b1);
    wait_drain(20);
    checks++;
    if (snap() !== base + {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0}) begin
      errors++; $display("FAIL tmo_pulses: got %h want %h", snap(), base + {8'd1, 24'd0, 8'd1, 8'd0});
    end
  endtask

  task automatic test_long_drop();
    logic [47:0] base;
    base = snap();
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) payload[i] = 8'(i * 7 + 3);
    send_frame(8'h01, 255, 8'h00, 1'b1);
    wait_valid(10);
    send_byte(PFX); send_byte(8'h01); send_byte(8'h02);
    checks++;
    if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", drop_err); end
    out_ready = 1'b1;
    wait_drain(400);
    checks++;
    if (snap() !== base + {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3}) begin
      errors++; $display("FAIL drop_pulses: got %h want %h", snap(), base + {8'd1, 32'd0, 8'd3});
    end
    send_frame(8'h02, 20, 8'h00, 1'b1);
    wait_valid(10);
    idle(5);
    #3 n_rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, out_dest} !== 18'd0) begin
      errors++; $display("FAIL mid_reset: got %h want 0", {out_valid, out_last, out_data, out_dest});
    end
    sb.delete();
    idle(2);
    n_rst = 1'b1;
    idle(3);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    payload[0] = 8'h5A; payload[1] = 8'hA5;
    send_frame(8'h03, 2, 8'h00, 1'b1);
    wait_drain(20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_err();
    test_dest_len();
    test_backpressure();
    test_timeout();
    test_long_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
